// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t            : FSM states of the serial subtractor
//   SUB_DEFAULT_WIDTH  : default operand/result width
//   SUB_CNT_W          : bit-counter width for the default width
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_DEFAULT_WIDTH = 8;
  localparam int SUB_CNT_W         = $clog2(SUB_DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_8bit_full_subtractor.sv
// Single full-subtractor bit cell, purely combinational.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit, x - y - bin
//   bout : borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when x=0,y=1, or when x==y and a borrow is propagating through.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first,
// one bit per clock, with valid/ready handshakes on both sides.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, b_in)
//   out_valid / out_ready: result handshake (diff, b_out, ovf, zero)
//   diff                 : a - b - b_in modulo 2^WIDTH
//   b_out                : final borrow (unsigned a < b + b_in)
//   ovf                  : signed overflow
//   zero                 : diff == 0
module serial_subtractor_8bit
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic [WIDTH-1:0] diff_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             b_out_r;
  logic             ovf_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             d_s;
  logic             nb_s;

  full_subtractor u_cell (
    .x    (a_sh_r[0]),
    .y    (b_sh_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (nb_s)
  );

  // The new difference bit enters at the MSB so the LSB-first stream lands in place.
  assign diff_nxt_s = {d_s, diff_r[WIDTH-1:1]};

  // Next-state logic of the handshake FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath and flag registers; handshake outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      diff_r      <= '0;
      cnt_r       <= '0;
      borrow_r    <= 1'b0;
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      b_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            borrow_r <= b_in;
            cnt_r    <= '0;
            // Sign bits kept aside: the shift registers are consumed during CALC.
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
          end
        end
        CALC: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          diff_r   <= diff_nxt_s;
          borrow_r <= nb_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            b_out_r <= nb_s;
            ovf_r   <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
            zero_r  <= (diff_nxt_s == '0);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign b_out     = b_out_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: directed cases, backpressure,
// mid-calculation reset and randomized transactions against an arithmetic model.
module tb_serial_subtractor_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       b_out;
  logic       ovf;
  logic       zero;

  int n_cmp;
  int n_mis;

  serial_subtractor_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one transaction and compare against plain arithmetic.
  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input int hold);
    logic [8:0] wide;
    logic [7:0] e_diff;
    logic       e_bout;
    logic       e_ovf;
    logic [7:0] held;
    int         n;
    wide   = {1'b0, ta} - {1'b0, tb} - {8'd0, tbin};
    e_diff = wide[7:0];
    e_bout = ({1'b0, ta} < ({1'b0, tb} + {8'd0, tbin}));
    e_ovf  = (ta[7] != tb[7]) && (e_diff[7] != ta[7]);

    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; b_in = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
    check_val("in_ready_calc", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("latency", n, 32'd8);
    check_val("diff", {24'd0, diff}, {24'd0, e_diff});
    check_val("b_out", {31'd0, b_out}, {31'd0, e_bout});
    check_val("ovf", {31'd0, ovf}, {31'd0, e_ovf});
    check_val("zero", {31'd0, zero}, {31'd0, (e_diff == 8'd0)});
    check_val("in_ready_done", {31'd0, in_ready}, 32'd0);
    held = diff;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("hold_diff", {24'd0, diff}, {24'd0, held});
      check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("release_valid", {31'd0, out_valid}, 32'd0);
    check_val("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'd0; b = 8'd0; b_in = 1'b0;
    #23;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_diff", {24'd0, diff}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(8'h50, 8'h30, 1'b0, 0);
    run_txn(8'h00, 8'h01, 1'b0, 0);
    run_txn(8'h80, 8'h01, 1'b0, 1);
    run_txn(8'h7F, 8'hFF, 1'b0, 0);
    run_txn(8'h05, 8'h04, 1'b1, 0);
    run_txn(8'hA5, 8'h3C, 1'b1, 5);

    // Reset partway through CALC, between clock edges.
    a = 8'hFF; b = 8'h00; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("midrst_diff", {24'd0, diff}, 32'd0);
    check_val("midrst_b_out", {31'd0, b_out}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(8'h10, 8'h01, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_txn(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
